// File: rtl/fetch_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// fetch_sequencer_pkg
// Shared definitions for the instruction-fetch sequencer:
//   - pc_src encodings produced by the branch unit
//   - fetch FSM state encodings
//   - PC increment helper (wraps modulo 2^32)
// -----------------------------------------------------------------------------
package fetch_sequencer_pkg;

    localparam int PC_WIDTH = 32;

    // Next-PC source selected by the branch unit.
    typedef enum logic [1:0] {
        PCS_SEQ = 2'b00,    // sequential, PC+4
        PCS_J   = 2'b01,    // j / jal
        PCS_BR  = 2'b10,    // conditional branch taken
        PCS_JR  = 2'b11     // jr / jalr
    } pc_src_e;

    // Fetch FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,   // one cycle after reset release
        ST_REQ   = 2'b01,   // request outstanding at pc
        ST_HOLD  = 2'b10,   // fetched word presented to decode
        ST_DRAIN = 2'b11    // squashed request still outstanding
    } fetch_state_e;

    // Sequential successor; natural 32-bit overflow gives the wrap to 0.
    function automatic logic [PC_WIDTH-1:0] pc_plus4(input logic [PC_WIDTH-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_sequencer_next_pc_calc.sv
// -----------------------------------------------------------------------------
// fetch_sequencer_next_pc_calc
// Combinational redirect-target mux.
// Ports:
//   id_pc_i      in  32  PC of the instruction in decode
//   pc_src_i     in  2   next-PC source (pc_src_e encoding)
//   imm16_i      in  16  branch offset (word offset, sign-extended)
//   idx26_i      in  26  jump index
//   rs_i         in  32  rs register value (jr target)
//   target_o     out 32  redirect target
//   misalign_o   out 1   jr target had non-zero low bits (target still aligned)
// -----------------------------------------------------------------------------
module fetch_sequencer_next_pc_calc
    import fetch_sequencer_pkg::*;
(
    input  logic [31:0] id_pc_i,
    input  logic [1:0]  pc_src_i,
    input  logic [15:0] imm16_i,
    input  logic [25:0] idx26_i,
    input  logic [31:0] rs_i,
    output logic [31:0] target_o,
    output logic        misalign_o
);

    logic [31:0] seq_pc;

    assign seq_pc = pc_plus4(id_pc_i);

    always_comb begin
        target_o   = seq_pc;
        misalign_o = 1'b0;
        case (pc_src_i)
            PCS_J:   target_o = {seq_pc[31:28], idx26_i, 2'b00};
            PCS_BR:  target_o = seq_pc + {{14{imm16_i[15]}}, imm16_i, 2'b00};
            PCS_JR: begin
                // Low bits are dropped so fetch stays word aligned; the
                // misalignment is only reported.
                target_o   = {rs_i[31:2], 2'b00};
                misalign_o = (rs_i[1:0] != 2'b00);
            end
            default: target_o = seq_pc;
        endcase
    end

endmodule

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
// Instruction-fetch controller: owns the PC, runs the imem req/ack handshake,
// presents fetched words to decode over valid/ready and squashes in-flight
// fetches when decode redirects (no delay slot).
// Ports:
//   clk_i          in  1   clock
//   rst_n_i        in  1   asynchronous active-low reset
//   imem_req_o     out 1   fetch request, held until imem_ack_i
//   imem_addr_o    out 32  fetch address, stable while request outstanding
//   imem_ack_i     in  1   1-cycle acknowledge, imem_rdata_i valid
//   imem_rdata_i   in  32  fetched word
//   if_valid_o     out 1   if_instr_o / if_pc_o valid
//   if_ready_i     in  1   decode accepts when valid & ready
//   if_instr_o     out 32  instruction word
//   if_pc_o        out 32  address of if_instr_o
//   id_valid_i     in  1   qualifies pc_src_i
//   id_pc_i        in  32  PC of instruction in decode
//   pc_src_i       in  2   next-PC source
//   id_imm16_i     in  16  branch offset
//   id_idx26_i     in  26  jump index
//   id_rs_i        in  32  jr target register
//   jr_misalign_o  out 1   pulse: jr target low bits were non-zero
// -----------------------------------------------------------------------------
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          PC_W     = 32
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    output logic            imem_req_o,
    output logic [PC_W-1:0] imem_addr_o,
    input  logic            imem_ack_i,
    input  logic [31:0]     imem_rdata_i,
    output logic            if_valid_o,
    input  logic            if_ready_i,
    output logic [31:0]     if_instr_o,
    output logic [PC_W-1:0] if_pc_o,
    input  logic            id_valid_i,
    input  logic [PC_W-1:0] id_pc_i,
    input  logic [1:0]      pc_src_i,
    input  logic [15:0]     id_imm16_i,
    input  logic [25:0]     id_idx26_i,
    input  logic [31:0]     id_rs_i,
    output logic            jr_misalign_o
);

    fetch_state_e    state_q;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] drain_addr_q;
    logic [PC_W-1:0] if_pc_q;
    logic [31:0]     if_instr_q;
    logic            if_valid_q;
    logic            jr_misalign_q;

    logic [PC_W-1:0] target_d;
    logic            misalign_d;
    logic            redirect_d;

    fetch_sequencer_next_pc_calc u_next_pc_calc (
        .id_pc_i    (id_pc_i),
        .pc_src_i   (pc_src_i),
        .imm16_i    (id_imm16_i),
        .idx26_i    (id_idx26_i),
        .rs_i       (id_rs_i),
        .target_o   (target_d),
        .misalign_o (misalign_d)
    );

    assign redirect_d = id_valid_i && (pc_src_i != PCS_SEQ);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            drain_addr_q  <= '0;
            if_pc_q       <= '0;
            if_instr_q    <= '0;
            if_valid_q    <= 1'b0;
            jr_misalign_q <= 1'b0;
        end else begin
            // misalign_d is only ever set for jr, so no extra source check.
            jr_misalign_q <= redirect_d && misalign_d;

            case (state_q)
                ST_IDLE: begin
                    state_q <= ST_REQ;
                    if (redirect_d) begin
                        pc_q <= target_d;
                    end
                end

                ST_REQ: begin
                    if (redirect_d) begin
                        pc_q <= target_d;
                        if (!imem_ack_i) begin
                            // Keep the bus address frozen while the old
                            // request completes; pc_q already moved on.
                            drain_addr_q <= pc_q;
                            state_q      <= ST_DRAIN;
                        end else begin
                            state_q <= ST_REQ;
                        end
                    end else if (imem_ack_i) begin
                        if_instr_q <= imem_rdata_i;
                        if_pc_q    <= pc_q;
                        if_valid_q <= 1'b1;
                        state_q    <= ST_HOLD;
                    end
                end

                ST_HOLD: begin
                    if (redirect_d) begin
                        pc_q       <= target_d;
                        if_valid_q <= 1'b0;
                        state_q    <= ST_REQ;
                    end else if (if_ready_i) begin
                        pc_q       <= pc_plus4(pc_q);
                        if_valid_q <= 1'b0;
                        state_q    <= ST_REQ;
                    end
                end

                ST_DRAIN: begin
                    // Later redirects just overwrite the pending target.
                    if (redirect_d) begin
                        pc_q <= target_d;
                    end
                    if (imem_ack_i) begin
                        state_q <= ST_REQ;
                    end
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign imem_req_o    = (state_q == ST_REQ) || (state_q == ST_DRAIN);
    assign imem_addr_o   = (state_q == ST_DRAIN) ? drain_addr_q : pc_q;
    assign if_valid_o    = if_valid_q;
    assign if_instr_o    = if_instr_q;
    assign if_pc_o       = if_pc_q;
    assign jr_misalign_o = jr_misalign_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: the expected stream of accepted PCs is
// kept in a queue (reset -> RESET_PC, accept -> +4, redirect -> new target),
// a monitor pops and compares on every decode accept.
module tb_fetch_sequencer;
    import fetch_sequencer_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [1:0]  pc_src;
    logic [15:0] id_imm16;
    logic [25:0] id_idx26;
    logic [31:0] id_rs;
    logic        jr_misalign;

    int checks = 0;
    int failures = 0;
    int accepts = 0;

    // memory model controls (written only by the main process)
    int mem_delay = 0;
    bit mem_fixed = 1'b1;
    bit inject_ack = 1'b0;
    logic [31:0] ack_log[$];

    // scoreboard
    logic [31:0] exp_q[$];
    bit mis_exp = 1'b0;

    fetch_sequencer #(.RESET_PC(RESET_PC), .PC_W(32)) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .imem_req_o    (imem_req),
        .imem_addr_o   (imem_addr),
        .imem_ack_i    (imem_ack),
        .imem_rdata_i  (imem_rdata),
        .if_valid_o    (if_valid),
        .if_ready_i    (if_ready),
        .if_instr_o    (if_instr),
        .if_pc_o       (if_pc),
        .id_valid_i    (id_valid),
        .id_pc_i       (id_pc),
        .pc_src_i      (pc_src),
        .id_imm16_i    (id_imm16),
        .id_idx26_i    (id_idx26),
        .id_rs_i       (id_rs),
        .jr_misalign_o (jr_misalign)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
    endfunction

    // Redirect target from the ISA rules, plain arithmetic.
    function automatic logic [31:0] ref_target(input logic [31:0] pc, input logic [1:0] src,
                                               input logic [15:0] imm, input logic [25:0] idx,
                                               input logic [31:0] rs);
        logic [31:0] nxt;
        int off;
        nxt = pc + 32'd4;
        off = $signed(imm);
        off = off * 4;
        case (src)
            2'b01:   return (nxt & 32'hF000_0000) | (32'(idx) * 32'd4);
            2'b10:   return nxt + 32'(off);
            2'b11:   return rs & 32'hFFFF_FFFC;
            default: return nxt;
        endcase
    endfunction

    // imem responder: ack after mem_delay cycles of request (random if !mem_fixed)
    initial begin : memory
        int cnt;
        logic [31:0] req_addr;
        cnt = -1;
        req_addr = '0;
        imem_ack = 1'b0;
        imem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            imem_ack = 1'b0;
            if (inject_ack) begin
                imem_ack = 1'b1;
                imem_rdata = 32'hDEAD_BEEF;
            end else if (rst_n && imem_req) begin
                if (cnt < 0) begin
                    cnt = mem_fixed ? mem_delay : int'($urandom_range(mem_delay, 0));
                    req_addr = imem_addr;
                end
                if (cnt == 0) begin
                    imem_ack = 1'b1;
                    imem_rdata = mem_word(imem_addr);
                    check("imem_addr_stable", imem_addr, req_addr);
                    ack_log.push_back(imem_addr);
                    cnt = -1;
                end else begin
                    cnt--;
                end
            end else begin
                cnt = -1;
            end
        end
    end

    // model: reacts to reset and to each issued redirect
    initial begin : model
        exp_q.push_back(RESET_PC);
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                exp_q.delete();
                exp_q.push_back(RESET_PC);
                mis_exp = 1'b0;
            end else begin
                mis_exp = id_valid && (pc_src == 2'b11) && (id_rs[1:0] != 2'b00);
                if (id_valid && pc_src != 2'b00) begin
                    exp_q.delete();
                    exp_q.push_back(ref_target(id_pc, pc_src, id_imm16, id_idx26, id_rs));
                end
            end
        end
    end

    // monitor: compare on every accept
    initial begin : monitor
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("jr_misalign", 32'(jr_misalign), 32'(mis_exp));
                if (if_valid && if_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL accept_unexpected: got pc %h expected none", if_pc);
                    end else begin
                        e = exp_q.pop_front();
                        check("if_pc", if_pc, e);
                        check("if_instr", if_instr, mem_word(e));
                        exp_q.push_back(e + 32'd4);
                        accepts++;
                        $display("accept pc=%h instr=%h", if_pc, if_instr);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_id();
        id_valid = 1'b0;
        pc_src = 2'b00;
    endtask

    task automatic redirect(input logic [1:0] src, input logic [31:0] pc,
                            input logic [15:0] imm, input logic [25:0] idx, input logic [31:0] rs);
        id_valid = 1'b1;
        pc_src = src;
        id_pc = pc;
        id_imm16 = imm;
        id_idx26 = idx;
        id_rs = rs;
        if_ready = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!if_valid && n < 40) begin
            tick();
            n++;
        end
        check(name, 32'(if_valid), 32'd1);
    endtask

    task automatic wait_req_noack(input string name);
        int n;
        n = 0;
        while (!(imem_req && !imem_ack && !if_valid) && n < 40) begin
            tick();
            n++;
        end
        check(name, 32'(imem_req && !imem_ack), 32'd1);
    endtask

    initial begin : main
        logic [31:0] held_instr;
        logic [31:0] held_pc;
        logic [31:0] old_addr;
        int n;
        if_ready = 1'b0;
        id_valid = 1'b0;
        pc_src = 2'b00;
        id_pc = '0;
        id_imm16 = '0;
        id_idx26 = '0;
        id_rs = '0;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_if_valid", 32'(if_valid), 32'd0);
        check("rst_if_instr", if_instr, 32'd0);
        check("rst_if_pc", if_pc, 32'd0);
        check("rst_jr_misalign", 32'(jr_misalign), 32'd0);

        // 1: sequential fetch, 1 IDLE cycle before first request
        rst_n = 1'b1;
        if_ready = 1'b1;
        #1;
        check("idle_no_req", 32'(imem_req), 32'd0);
        @(negedge clk);
        check("first_req", 32'(imem_req), 32'd1);
        check("first_addr", imem_addr, RESET_PC);
        n = 0;
        while (ack_log.size() < 3 && n < 50) begin
            tick();
            n++;
        end
        check("seq_ack_count_ok", 32'(ack_log.size() >= 3), 32'd1);
        if (ack_log.size() >= 3) begin
            check("seq_addr0", ack_log[0], 32'h0);
            check("seq_addr1", ack_log[1], 32'h4);
            check("seq_addr2", ack_log[2], 32'h8);
        end

        // 2: decode stall in HOLD
        tick();
        if_ready = 1'b0;
        wait_valid("stall_wait_valid");
        held_instr = if_instr;
        held_pc = if_pc;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_valid", 32'(if_valid), 32'd1);
            check("stall_instr", if_instr, held_instr);
            check("stall_pc", if_pc, held_pc);
            check("stall_no_req", 32'(imem_req), 32'd0);
        end

        // 3: branch redirect while HOLD
        redirect(2'b10, 32'h0000_0100, 16'hFFFE, 26'h0, 32'h0);
        tick();
        clear_id();
        check("br_drop_valid", 32'(if_valid), 32'd0);
        check("br_req", 32'(imem_req), 32'd1);
        check("br_addr", imem_addr, 32'h0000_00FC);
        if_ready = 1'b1;
        repeat (4) tick();

        // 4: jr while request outstanding -> DRAIN
        mem_delay = 3;
        wait_req_noack("jr_wait_req");
        old_addr = imem_addr;
        redirect(2'b11, 32'h0, 16'h0, 26'h0, 32'h0000_2003);
        tick();
        clear_id();
        check("jr_misalign_pulse", 32'(jr_misalign), 32'd1);
        n = 0;
        while (n < 10) begin
            check("drain_addr", imem_addr, old_addr);
            check("drain_req", 32'(imem_req), 32'd1);
            check("drain_no_valid", 32'(if_valid), 32'd0);
            if (imem_ack) break;
            tick();
            n++;
        end
        check("drain_ack_seen", 32'(imem_ack), 32'd1);
        tick();
        check("jr_req", 32'(imem_req), 32'd1);
        check("jr_addr", imem_addr, 32'h0000_2000);
        check("jr_misalign_once", 32'(jr_misalign), 32'd0);
        if_ready = 1'b1;
        repeat (6) tick();

        // 5: jump and PC wrap
        mem_delay = 0;
        if_ready = 1'b0;
        wait_valid("j_wait_valid");
        redirect(2'b01, 32'hF000_0010, 16'h0, 26'h000_0040, 32'h0);
        tick();
        clear_id();
        check("j_addr", imem_addr, 32'hF000_0100);
        wait_valid("wrap_wait_valid0");
        redirect(2'b11, 32'h0, 16'h0, 26'h0, 32'hFFFF_FFFC);
        tick();
        clear_id();
        check("wrap_jr_addr", imem_addr, 32'hFFFF_FFFC);
        wait_valid("wrap_wait_valid1");
        if_ready = 1'b1;
        tick();
        if_ready = 1'b0;
        check("wrap_req", 32'(imem_req), 32'd1);
        check("wrap_addr", imem_addr, 32'h0000_0000);
        if_ready = 1'b1;
        repeat (4) tick();

        // 6: reset mid-DRAIN with late ack
        mem_delay = 3;
        wait_req_noack("rst_wait_req");
        old_addr = imem_addr;
        redirect(2'b01, 32'h0000_1000, 16'h0, 26'h0001234, 32'h0);
        tick();
        clear_id();
        check("rst_drain_addr", imem_addr, old_addr);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_req", 32'(imem_req), 32'd0);
        check("midrst_valid", 32'(if_valid), 32'd0);
        check("midrst_pc", if_pc, 32'd0);
        check("midrst_instr", if_instr, 32'd0);
        tick();
        inject_ack = 1'b1;
        tick();
        inject_ack = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("late_ack_no_valid", 32'(if_valid), 32'd0);
        check("rerst_req", 32'(imem_req), 32'd1);
        check("rerst_addr", imem_addr, RESET_PC);
        if_ready = 1'b1;
        repeat (8) tick();

        // randomized traffic
        mem_fixed = 1'b0;
        mem_delay = 3;
        for (int c = 0; c < 2500; c++) begin
            int r;
            r = int'($urandom_range(99, 0));
            if (r < 8) begin
                redirect(2'($urandom_range(3, 1)), $urandom, 16'($urandom), 26'($urandom),
                         ($urandom_range(1, 0) != 0) ? ($urandom & 32'hFFFF_FFFC) : $urandom);
            end else begin
                if (r < 20) begin
                    id_valid = 1'b0;
                    pc_src = 2'($urandom_range(3, 1));
                end else begin
                    id_valid = 1'($urandom_range(1, 0));
                    pc_src = 2'b00;
                end
                id_pc = $urandom;
                id_rs = $urandom;
                if_ready = ($urandom_range(99, 0) < 70);
            end
            tick();
        end
        clear_id();
        if_ready = 1'b1;
        repeat (20) tick();
        check("accepts_progress", 32'(accepts > 200), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
